transpose_column_reader: RTL and testbench
==========================================

// Module: transpose_column_reader
// PURPOSE
//  Read-side sequencer for the skewed transpose bank array. After a full NUM_PE x NUM_PE tile has been
//  written (row r of the input tile stored at address r, element c placed in bank (c+r) mod NUM_MG), this
//  block issues per-bank skewed read addresses, un-rotates the returned bank words and streams the
//  tile's columns out as rows with a valid/ready handshake. It sits between the bank array read ports and the PE array.
// PARAMETERS
//  DATA_WIDTH  64       width of one element
//  NUM_MG      8        number of memory banks; power of two, >= 2
//  NUM_PE      NUM_MG   elements per row and rows per tile; must equal NUM_MG
//  ADDR_WIDTH  $clog2(NUM_PE)  localparam, bank address and row index width
// PORTS
//  clk          in   1                     clock, all state on posedge
//  rst          in   1                     synchronous, active-high reset
//  start        in   1                     begin reading one tile; ignored while busy
//  busy         out  1                     high from the cycle after start is accepted until done
//  done         out  1                     single-cycle pulse when the last column row is accepted downstream
//  rd_en        out  1                     bank read strobe, the same for all banks
//  read_addr    out  ADDR_WIDTH x NUM_MG   per-bank read address
//  read_data    in   DATA_WIDTH x NUM_MG   per-bank read data, valid the cycle after rd_en
//  out_val      out  1                     output_row/row_idx valid
//  out_rdy      in   1                     downstream accept; a transfer happens when out_val && out_rdy
//  output_row   out  DATA_WIDTH x NUM_PE   transposed row (column k of the tile)
//  row_idx      out  ADDR_WIDTH            k, the index of the column currently presented
// BEHAVIOUR
//  - Reset: busy=0, done=0, rd_en=0, out_val=0, read_addr=0, row_idx=0, output_row=0, all counters and skid entries cleared.
//    Reset wins over every other event in the same cycle, including mid-tile. Any partial tile is discarded.
//  - FSM: IDLE -> (start) READ -> (last read issued) DRAIN -> (last transfer) IDLE. done pulses on that last transfer.
//  - READ, issue k (k = 0..NUM_PE-1): rd_en=1 and read_addr[b] = (b - k) mod NUM_PE, wrapping naturally in ADDR_WIDTH bits.
//  - Return (cycle after issue): output_row[r] = read_data[(k + r) mod NUM_MG] for r = 0..NUM_PE-1, tagged row_idx=k.
//  - Pipeline: issue in cycle t, bank data in t+1, registered into a 2-entry output skid. out_val can first rise in t+2.
//    Latency from the start cycle to the first out_val is 3 cycles.
//  - Flow control: a read is issued only while (reads in flight + skid occupancy) < 2.
//    With out_rdy held high this gives one column per cycle. The skid never overflows and data is never dropped.
//  - out_val/output_row/row_idx hold stable while out_val && !out_rdy. Columns leave in order 0..NUM_PE-1 with no gaps or repeats.
//  - start while busy: ignored, no effect on the current tile. start in the same cycle as done: accepted, new tile begins.
//  - Counters are ADDR_WIDTH+1 bits wide so that the terminal count NUM_PE is distinguishable from 0.
// STRUCTURE
//  - Shared package transpose_pkg: ADDR_WIDTH function of NUM_PE, the bank_skew(b,k) helper, and the reader FSM state
//    enum (IDLE, READ, DRAIN). The writer side uses the same bank_skew, so the placement rule is defined in one place.
//  - One sub-module: transpose_rotate, a combinational left barrel rotate of NUM_MG words by k, in log2 stages.
//  - Top level holds the FSM, issue/return counters, in-flight flag, 2-entry skid and done generation.
// TESTING
//  - NUM_MG=4, tile T[r][c]=16r+c pre-loaded with the skew, out_rdy=1 -> rows 0..3 on consecutive cycles.
//    Row k = {k, 16+k, 32+k, 48+k}. First out_val 3 cycles after start. done pulses with row 3.
//  - Same tile, out_rdy toggled 1,0,0,1,0,1... -> identical row sequence, outputs stable while stalled, rd_en never >2 ahead.
//  - start asserted again while busy at row 1 -> ignored, exactly 4 rows emitted, one done pulse.
//  - rst asserted for one cycle after row 1 is accepted -> next cycle all outputs 0, busy=0.
//    A new start then streams rows 0..3 correctly.
//  - start in the same cycle as done, out_rdy=1 -> second tile's row 0 appears 3 cycles later, no lost or duplicated rows.
//  - NUM_MG=8, random tile, random out_rdy over 100 tiles -> scoreboard: output row k == column k of the tile.

Source files
------------

// File: rtl/transpose_pkg.sv
// Shared definitions for the skewed transpose bank array: address width, the
// bank placement/skew rule and the reader FSM state encoding.
package transpose_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } rd_state_e;

  function automatic int unsigned addr_width(input int unsigned n);
    return $clog2(n);
  endfunction

  // Row address holding column k inside bank b. Element c of row r lives in
  // bank (c + r) mod n, so bank b holds column k at row (b - k) mod n.
  // n is a power of two, so the mask performs the modulo.
  function automatic int unsigned bank_skew(input int unsigned b, input int unsigned k,
                                            input int unsigned n);
    return (b - k) & (n - 1);
  endfunction

endpackage

// File: rtl/transpose_column_reader_if.sv
// Bank read port plus output stream of the transpose column reader.
// master = the reader itself, slave = bank array / PE array side.
interface transpose_column_reader_if
  import transpose_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_MG     = 8
);
  localparam int unsigned ADDR_WIDTH = addr_width(NUM_MG);

  logic                                  start;
  logic                                  busy;
  logic                                  done;
  logic                                  rd_en;
  logic [NUM_MG-1:0][ADDR_WIDTH-1:0]     read_addr;
  logic [NUM_MG-1:0][DATA_WIDTH-1:0]     read_data;
  logic                                  out_val;
  logic                                  out_rdy;
  logic [NUM_MG-1:0][DATA_WIDTH-1:0]     output_row;
  logic [ADDR_WIDTH-1:0]                 row_idx;

  modport master (
    input  start, read_data, out_rdy,
    output busy, done, rd_en, read_addr, out_val, output_row, row_idx
  );

  modport slave (
    output start, read_data, out_rdy,
    input  busy, done, rd_en, read_addr, out_val, output_row, row_idx
  );

endinterface

// File: rtl/transpose_rotate.sv
// Combinational left rotate of NUM_MG words: rotated[r] = words[(r + shift) mod NUM_MG],
// built as log2(NUM_MG) power-of-two stages.
module transpose_rotate
  import transpose_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 64,
  parameter  int unsigned NUM_MG     = 8,
  localparam int unsigned SHIFT_W    = addr_width(NUM_MG)
) (
  input  logic [NUM_MG-1:0][DATA_WIDTH-1:0] words,
  input  logic [SHIFT_W-1:0]                shift,
  output logic [NUM_MG-1:0][DATA_WIDTH-1:0] rotated
);

  logic [NUM_MG-1:0][DATA_WIDTH-1:0] stage [SHIFT_W+1];

  assign stage[0] = words;

  for (genvar s = 0; s < SHIFT_W; s++) begin : g_stage
    for (genvar r = 0; r < NUM_MG; r++) begin : g_word
      localparam int unsigned SRC = (r + (1 << s)) % NUM_MG;
      assign stage[s+1][r] = shift[s] ? stage[s][SRC] : stage[s][r];
    end
  end

  assign rotated = stage[SHIFT_W];

endmodule

// File: rtl/transpose_column_reader.sv
// Read-side sequencer of the skewed transpose bank array: issues skewed per-bank
// reads, un-rotates the returned words and streams tile columns out as rows.
module transpose_column_reader
  import transpose_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_MG     = 8,
  parameter int unsigned NUM_PE     = NUM_MG
) (
  input logic                        clk,
  input logic                        rst,
  transpose_column_reader_if.master  bus
);

  localparam int unsigned ADDR_WIDTH = addr_width(NUM_PE);

  typedef logic [NUM_PE-1:0][DATA_WIDTH-1:0] row_t;

  typedef struct packed {
    row_t                  row;
    logic [ADDR_WIDTH-1:0] idx;
  } skid_entry_t;

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH:0]   issue_cnt;
  logic [ADDR_WIDTH:0]   xfer_cnt;
  logic                  in_flight;
  logic [ADDR_WIDTH-1:0] in_flight_k;
  skid_entry_t           skid_q [2];
  skid_entry_t           skid_d [2];
  logic [1:0]            skid_cnt, skid_cnt_d;
  logic [1:0]            occupancy;
  logic                  issue, xfer, last_issue, last_xfer, start_accept;
  row_t                  rot_row;

  transpose_rotate #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_MG     (NUM_MG)
  ) u_rotate (
    .words   (bus.read_data),
    .shift   (in_flight_k),
    .rotated (rot_row)
  );

  // Entries that will still be pending after this cycle's transfer; keeping this
  // below two lets a read issue in the same cycle a row leaves, so a ready
  // consumer sees one column per cycle without ever overfilling the skid.
  assign xfer       = bus.out_val && bus.out_rdy;
  assign occupancy  = skid_cnt + {1'b0, in_flight} - {1'b0, xfer};
  assign issue      = (state_q == READ) && (occupancy < 2'd2);
  assign last_issue = issue && (issue_cnt == (ADDR_WIDTH + 1)'(NUM_PE - 1));
  assign last_xfer  = xfer && (xfer_cnt == (ADDR_WIDTH + 1)'(NUM_PE - 1));
  assign start_accept = bus.start &&
                        ((state_q == IDLE) || ((state_q == DRAIN) && last_xfer));

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = READ;
      READ:    if (last_issue) state_d = DRAIN;
      DRAIN:   if (last_xfer) state_d = bus.start ? READ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.read_addr = '0;
    if (issue) begin
      for (int unsigned b = 0; b < NUM_MG; b++) begin
        bus.read_addr[b] = ADDR_WIDTH'(bank_skew(b, 32'(issue_cnt), NUM_PE));
      end
    end
  end

  // Skid: slot 0 is the presented row; a departing row shifts slot 1 down,
  // and returning bank data lands in the first free slot behind it.
  always_comb begin
    skid_d     = skid_q;
    skid_cnt_d = skid_cnt;
    if (xfer) begin
      skid_d[0]  = skid_q[1];
      skid_cnt_d = skid_cnt - 2'd1;
    end
    if (in_flight) begin
      if (skid_cnt_d == 2'd0) skid_d[0] = '{row: rot_row, idx: in_flight_k};
      else                    skid_d[1] = '{row: rot_row, idx: in_flight_k};
      skid_cnt_d = skid_cnt_d + 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_cnt   <= '0;
      xfer_cnt    <= '0;
      in_flight   <= 1'b0;
      in_flight_k <= '0;
      skid_cnt    <= '0;
      // NOTE: the skid entries are reset (unlike a RAM) because slot 0 drives
      // output_row and row_idx directly, which must read zero out of reset.
      skid_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      in_flight   <= issue;
      in_flight_k <= issue_cnt[ADDR_WIDTH-1:0];
      skid_q      <= skid_d;
      skid_cnt    <= skid_cnt_d;
      if (start_accept)  issue_cnt <= '0;
      else if (issue)    issue_cnt <= issue_cnt + 1'b1;
      if (start_accept)  xfer_cnt <= '0;
      else if (xfer)     xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = last_xfer && (state_q == DRAIN);
  assign bus.rd_en      = issue;
  assign bus.out_val    = (skid_cnt != 2'd0);
  assign bus.output_row = skid_q[0].row;
  assign bus.row_idx    = skid_q[0].idx;

endmodule

// File: tb/tb_transpose_column_reader.sv
// Bench for transpose_column_reader: directed runs on a 4-bank instance and a
// randomized 100-tile scoreboard run on an 8-bank instance.
module tb_transpose_column_reader;

  localparam int unsigned DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int   n_cmp = 0;
  int   n_bad = 0;

  transpose_column_reader_if #(.DATA_WIDTH(DW), .NUM_MG(4)) ifa ();
  transpose_column_reader_if #(.DATA_WIDTH(DW), .NUM_MG(8)) ifb ();

  transpose_column_reader #(.DATA_WIDTH(DW), .NUM_MG(4), .NUM_PE(4)) dut_a (
    .clk (clk), .rst (rst_a), .bus (ifa)
  );
  transpose_column_reader #(.DATA_WIDTH(DW), .NUM_MG(8), .NUM_PE(8)) dut_b (
    .clk (clk), .rst (rst_b), .bus (ifb)
  );

  // Tiles as the writer sees them, and the banks they are placed into.
  logic [DW-1:0] tile_a [4][4];
  logic [DW-1:0] mem_a  [4][4];
  logic [DW-1:0] tile_b [8][8];
  logic [DW-1:0] mem_b  [8][8];

  // Bank array: synchronous read, data one cycle after rd_en.
  always @(posedge clk) begin
    if (ifa.rd_en) for (int b = 0; b < 4; b++) ifa.read_data[b] <= mem_a[b][ifa.read_addr[b]];
    if (ifb.rd_en) for (int b = 0; b < 8; b++) ifb.read_data[b] <= mem_b[b][ifb.read_addr[b]];
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_a();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) mem_a[(c + r) % 4][r] = tile_a[r][c];
  endtask

  task automatic load_b();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mem_b[(c + r) % 8][r] = tile_b[r][c];
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_busy"},       512'(ifa.busy),       512'(0));
    check({tag, "_done"},       512'(ifa.done),       512'(0));
    check({tag, "_rd_en"},      512'(ifa.rd_en),      512'(0));
    check({tag, "_out_val"},    512'(ifa.out_val),    512'(0));
    check({tag, "_row_idx"},    512'(ifa.row_idx),    512'(0));
    check({tag, "_output_row"}, 512'(ifa.output_row), 512'(0));
    check({tag, "_read_addr"},  512'(ifa.read_addr),  512'(0));
  endtask

  // Runs one tile on instance A. The caller has raised start in the current
  // cycle; loop iteration c is the c-th cycle after the start cycle.
  task automatic run_a(input logic [15:0] rdy_pat, input int plen, input int inject_at,
                       input int abort_at, input bit chain);
    int            n_acc = 0;
    int            n_iss = 0;
    int            first = -1;
    bit            injected = 0;
    bit            aborted = 0;
    bit            prev_stall = 0;
    logic [255:0]  prev_row = '0;
    logic [1:0]    prev_idx = '0;
    logic [511:0]  exp_row;
    logic [7:0]    exp_addr;
    for (int c = 1; c <= 60 && n_acc < 4; c++) begin
      @(negedge clk);
      ifa.start = 1'b0;
      if (inject_at >= 0 && n_acc == inject_at && !injected) begin
        ifa.start = 1'b1;
        injected  = 1;
      end
      ifa.out_rdy = rdy_pat[(c - 1) % plen];
      #1;
      if (ifa.rd_en) begin
        for (int b = 0; b < 4; b++) exp_addr[b*2 +: 2] = 2'((b + 4 - n_iss) % 4);
        check("a_read_addr", 512'(ifa.read_addr), 512'(exp_addr));
        n_iss++;
      end
      if (ifa.out_val && first < 0) begin
        first = c;
        check("a_first_latency", 512'(c), 512'(3));
      end
      if (prev_stall) begin
        check("a_stall_val", 512'(ifa.out_val),    512'(1));
        check("a_stall_row", 512'(ifa.output_row), 512'(prev_row));
        check("a_stall_idx", 512'(ifa.row_idx),    512'(prev_idx));
      end
      if (ifa.out_val && ifa.out_rdy) begin
        exp_row = '0;
        for (int r = 0; r < 4; r++) exp_row[r*DW +: DW] = tile_a[r][n_acc];
        check("a_row_idx", 512'(ifa.row_idx), 512'(n_acc));
        check("a_row",     512'(ifa.output_row), exp_row);
        check("a_done",    512'(ifa.done), 512'(n_acc == 3));
        n_acc++;
      end else begin
        check("a_done_quiet", 512'(ifa.done), 512'(0));
      end
      check("a_reads_ahead", 512'(n_iss - n_acc <= 2), 512'(1));
      prev_stall = ifa.out_val && !ifa.out_rdy;
      prev_row   = ifa.output_row;
      prev_idx   = ifa.row_idx;
      if (abort_at >= 0 && n_acc == abort_at) begin
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        check_idle_a("a_mid_reset");
        aborted = 1;
        break;
      end
      if (chain && n_acc == 4) ifa.start = 1'b1;
    end
    if (!aborted) check("a_row_count", 512'(n_acc), 512'(4));
  endtask

  // One random tile on instance B against the column scoreboard.
  task automatic run_b(input int tile_no);
    int            n_acc = 0;
    int            n_iss = 0;
    int            first = -1;
    bit            prev_stall = 0;
    logic [511:0]  prev_row = '0;
    logic [2:0]    prev_idx = '0;
    logic [511:0]  exp_row;
    logic [23:0]   exp_addr;
    for (int c = 1; c <= 200 && n_acc < 8; c++) begin
      @(negedge clk);
      ifb.start   = 1'b0;
      ifb.out_rdy = ($urandom_range(0, 3) != 0);
      #1;
      if (ifb.rd_en) begin
        for (int b = 0; b < 8; b++) exp_addr[b*3 +: 3] = 3'((b + 8 - n_iss) % 8);
        check("b_read_addr", 512'(ifb.read_addr), 512'(exp_addr));
        n_iss++;
      end
      if (ifb.out_val && first < 0) begin
        first = c;
        check("b_first_latency", 512'(c), 512'(3));
      end
      if (prev_stall) begin
        check("b_stall_row", 512'(ifb.output_row), prev_row);
        check("b_stall_idx", 512'(ifb.row_idx),    512'(prev_idx));
      end
      if (ifb.out_val && ifb.out_rdy) begin
        exp_row = '0;
        for (int r = 0; r < 8; r++) exp_row[r*DW +: DW] = tile_b[r][n_acc];
        check("b_row_idx", 512'(ifb.row_idx), 512'(n_acc));
        check("b_row",     512'(ifb.output_row), exp_row);
        check("b_done",    512'(ifb.done), 512'(n_acc == 7));
        n_acc++;
      end
      check("b_reads_ahead", 512'(n_iss - n_acc <= 2), 512'(1));
      prev_stall = ifb.out_val && !ifb.out_rdy;
      prev_row   = 512'(ifb.output_row);
      prev_idx   = ifb.row_idx;
    end
    if (n_acc != 8) $display("tile %0d ended early", tile_no);
    check("b_row_count", 512'(n_acc), 512'(8));
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.start = 1'b0; ifa.out_rdy = 1'b0;
    ifb.start = 1'b0; ifb.out_rdy = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) tile_a[r][c] = DW'(16 * r + c);
    load_a();
    repeat (2) @(negedge clk);
    #1;
    check_idle_a("a_reset");
    check("b_reset_out_val", 512'(ifb.out_val), 512'(0));
    check("b_reset_busy",    512'(ifb.busy),    512'(0));
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Free-flowing consumer.
    ifa.start = 1'b1;
    run_a(16'h0001, 1, -1, -1, 1'b0);
    @(negedge clk);
    #1;
    check("a_idle_after_tile", 512'(ifa.busy), 512'(0));

    // Consumer stalls with ready pattern 1,0,0,1,0,1 repeating.
    ifa.start = 1'b1;
    run_a(16'b101001, 6, -1, -1, 1'b0);

    // start pulsed again while row 1 is presented; must be ignored.
    @(negedge clk);
    ifa.start = 1'b1;
    run_a(16'h0001, 1, 1, -1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ifa.start = 1'b0;
      #1;
      check("a_ignored_start_busy", 512'(ifa.busy),    512'(0));
      check("a_ignored_start_val",  512'(ifa.out_val), 512'(0));
    end

    // Reset one cycle after row 1 is accepted, then a clean tile.
    ifa.start = 1'b1;
    run_a(16'h0001, 1, -1, 2, 1'b0);
    @(negedge clk);
    ifa.start = 1'b1;
    run_a(16'h0001, 1, -1, -1, 1'b0);

    // Back-to-back tiles: start in the same cycle as done.
    @(negedge clk);
    ifa.start = 1'b1;
    run_a(16'h0001, 1, -1, -1, 1'b1);
    run_a(16'h0001, 1, -1, -1, 1'b0);
    @(negedge clk);
    ifa.start = 1'b0;
    #1;
    check("a_idle_after_chain", 512'(ifa.busy), 512'(0));

    // Random tiles and random back-pressure on the 8-bank instance.
    for (int t = 0; t < 100; t++) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) tile_b[r][c] = {$urandom, $urandom};
      load_b();
      @(negedge clk);
      ifb.start = 1'b1;
      run_b(t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
